ps2_scancode_rx: RTL
====================

// Module: ps2_scancode_rx
// PURPOSE
//  Receives PS/2 keyboard frames on the raw ps2_clk/ps2_data pins and delivers make-code bytes
//  as a one-cycle strobe. It drops break sequences (F0 xx) and flags extended (E0 xx) codes.
//  It sits directly upstream of the scancode-to-ASCII lookup: scancode feeds that lookup, and
//  scan_valid qualifies it for the message buffer that feeds the RSA datapath.
// PARAMETERS
//  FILTER_LEN     8        system clocks ps2_clk must hold a new level before it is accepted
//  TIMEOUT_CYCLES 200000   idle clocks inside a frame before abort (2 ms at 100 MHz)
//  DROP_BREAK     1        1: suppress the byte after F0; 0: emit it with is_break=1
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  rst        in   1  asynchronous, active-high reset
//  ps2_clk    in   1  raw PS/2 clock pin, asynchronous to clk
//  ps2_data   in   1  raw PS/2 data pin, asynchronous to clk
//  scancode   out  8  last delivered code byte, held until the next scan_valid
//  scan_valid out  1  one-cycle strobe; scancode/extended/is_break are valid in this cycle
//  extended   out  1  delivered code was preceded by E0
//  is_break   out  1  delivered code was preceded by F0 (only ever 1 when DROP_BREAK=0)
//  frame_err  out  1  one-cycle strobe on a start, parity, stop or timeout error
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, shift register 0, pending flags 0, timeout counter 0.
//  Input conditioning:
//   - Both pins go through a 2-FF synchroniser.
//   - ps2_clk then goes through a FILTER_LEN stability counter.
//   - fall = 1-cycle pulse when the filtered ps2_clk goes 1->0. Data is sampled from synced ps2_data on fall.
//  Frame FSM (advances only on fall):
//   - IDLE: data=0 -> DATA with bit count 0. data=1 -> stay IDLE, no error (spurious edge).
//   - DATA: shift in LSB first. After the 8th bit go to PARITY.
//   - PARITY: store the bit. Odd parity over the 8 data bits plus the parity bit is required.
//   - STOP: data must be 1 and parity must be good -> byte_rdy (internal, 1 cycle). Otherwise frame_err.
//     Either way return to IDLE.
//  Timeout: in any state except IDLE, the counter increments each clk and clears on fall.
//   - Reaching TIMEOUT_CYCLES-1 -> frame_err, FSM to IDLE, shift register cleared.
//  Any frame_err also clears the break_pend and ext_pend flags.
//  Byte decoder (acts on byte_rdy):
//   - byte E0 -> ext_pend=1, no output.
//   - byte F0 -> brk_pend=1, no output.
//   - other byte with brk_pend=1 and DROP_BREAK=1 -> no output, clear both flags.
//   - other byte otherwise -> scan_valid=1 and scancode=byte in the next cycle;
//     extended=ext_pend, is_break=brk_pend; clear both flags.
//  Latency: scan_valid asserts exactly 1 clk after the cycle in which the stop-bit fall is detected.
//   That is FILTER_LEN+3 clks after the pin edge.
//  frame_err asserts 1 clk after the detecting cycle. scan_valid and frame_err are never high together.
//  extended/is_break hold with scancode. No backpressure: the consumer must accept every strobe.
//  Frames are >=60 us apart, so consumer overrun is not possible.
//  A new falling edge in the same cycle as a timeout: the timeout wins and the edge is ignored.
//  Reset asserted mid-frame: the partial frame is discarded, no strobe is emitted, and
//   decoding resumes at the next start bit.
// STRUCTURE
//  Package ps2_pkg:
//   - PS2_BREAK=8'hF0, PS2_EXT=8'hE0
//   - frame state enum {IDLE,DATA,PARITY,STOP}
//   - PS2_DATA_BITS=8
//  Sub-module ps2_pin_filter: synchroniser, FILTER_LEN glitch filter and falling-edge pulse.
//   Instantiated once for ps2_clk. ps2_data uses only its synchroniser path.
//  Top level: frame FSM, timeout counter, byte decoder and output registers.
// TESTING (bench drives PS/2 at 12.5 kHz, clk 100 MHz, FILTER_LEN=8, small TIMEOUT_CYCLES for sim)
//  1 Frame 0x1C with parity 0 and stop 1 -> one scan_valid, scancode=8'h1C, extended=0,
//    frame_err=0; downstream lookup yields "A".
//  2 Bytes F0,1C with DROP_BREAK=1 -> no scan_valid. Then 0x16 -> scan_valid with scancode=8'h16 and is_break=0.
//    Repeat F0,1C with DROP_BREAK=0 -> scan_valid with scancode=8'h1C and is_break=1.
//  3 Bytes E0,75 -> single scan_valid with scancode=8'h75 and extended=1.
//    The next plain 0x1C gives extended=0.
//  4 Frame 0x1C with parity bit flipped -> frame_err pulse, no scan_valid.
//    Next good 0x45 -> scancode=8'h45.
//  5 Send start + 4 bits, then idle -> frame_err exactly TIMEOUT_CYCLES after the last edge.
//    E0 before the abort is forgotten: the following 0x1C gives extended=0.
//  6 Assert rst after 6 bits of a frame -> all outputs 0 with no strobe.
//    Glitch of <FILTER_LEN clks on ps2_clk during the next frame -> ignored; frame 0x32 decodes correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 receiver constants and the frame state type
package ps2_pkg;
    localparam logic [7:0] PS2_BREAK     = 8'hF0;
    localparam logic [7:0] PS2_EXT       = 8'hE0;
    localparam int         PS2_DATA_BITS = 8;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;
endpackage

// File: rtl/ps2_pin_filter.sv
// ps2_pin_filter: synchronises both PS/2 pins, glitch-filters ps2_clk and emits its falling-edge pulse
module ps2_pin_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_clk,
    input  logic pin_data,
    output logic fall,
    output logic data_sync
);
    localparam int CW = $clog2(FILTER_LEN + 1);
    logic [1:0]    clk_sync, dat_sync;
    logic          clk_filt;
    logic [CW-1:0] cnt;
    // Synchronisers and filter reset to the bus idle level so reset never fakes an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_filt <= 1'b1;
            cnt      <= '0;
            fall     <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], pin_clk};
            dat_sync <= {dat_sync[0], pin_data};
            fall     <= 1'b0;
            if (clk_sync[1] == clk_filt) cnt <= '0;
            else if (cnt == CW'(FILTER_LEN - 1)) begin
                cnt      <= '0;
                clk_filt <= clk_sync[1];
                fall     <= ~clk_sync[1];
            end else cnt <= cnt + 1'b1;
        end
    end
    assign data_sync = dat_sync[1];
endmodule

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: PS/2 keyboard frame receiver delivering make codes qualified by E0/F0 prefixes
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter bit DROP_BREAK     = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       scan_valid,
    output logic       extended,
    output logic       is_break,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(PS2_DATA_BITS);
    frame_state_t             state, state_nxt;
    logic                     fall, data_s, tmo, par_ok, byte_rdy, err_det;
    logic                     par_bit, ext_pend, brk_pend;
    logic [PS2_DATA_BITS-1:0] shift;
    logic [BW-1:0]            bit_cnt;
    logic [TW-1:0]            tcnt;

    ps2_pin_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk       (clk),
        .rst       (rst),
        .pin_clk   (ps2_clk),
        .pin_data  (ps2_data),
        .fall      (fall),
        .data_sync (data_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // A timeout takes priority over an edge arriving in the same cycle
    always_comb begin
        state_nxt = state;
        if (tmo) state_nxt = IDLE;
        else if (fall)
            case (state)
                IDLE:    state_nxt = data_s ? IDLE : DATA;
                DATA:    state_nxt = (bit_cnt == BW'(PS2_DATA_BITS - 1)) ? PARITY : DATA;
                PARITY:  state_nxt = STOP;
                default: state_nxt = IDLE;
            endcase
    end

    always_comb begin
        tmo      = (state != IDLE) && (tcnt == TW'(TIMEOUT_CYCLES - 1));
        par_ok   = ^{shift, par_bit};
        byte_rdy = !tmo && fall && (state == STOP) && data_s && par_ok;
        err_det  = tmo || (fall && (state == STOP) && !(data_s && par_ok));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift   <= '0;
            bit_cnt <= '0;
            par_bit <= 1'b0;
            tcnt    <= '0;
        end else begin
            tcnt <= (state == IDLE || fall || tmo) ? '0 : tcnt + 1'b1;
            if (tmo) begin
                shift   <= '0;
                bit_cnt <= '0;
            end else if (fall) begin
                if (state == IDLE) begin
                    shift   <= '0;
                    bit_cnt <= '0;
                end
                if (state == DATA) begin
                    shift   <= {data_s, shift[PS2_DATA_BITS-1:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                end
                if (state == PARITY) par_bit <= data_s;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {scancode, scan_valid, extended, is_break, frame_err} <= '0;
            {ext_pend, brk_pend} <= 2'b00;
        end else begin
            scan_valid <= 1'b0;
            frame_err  <= err_det;
            if (err_det) {ext_pend, brk_pend} <= 2'b00;
            else if (byte_rdy) begin
                if (shift == PS2_EXT) ext_pend <= 1'b1;
                else if (shift == PS2_BREAK) brk_pend <= 1'b1;
                else begin
                    {ext_pend, brk_pend} <= 2'b00;
                    if (!(brk_pend && DROP_BREAK)) begin
                        scan_valid <= 1'b1;
                        scancode   <= shift;
                        extended   <= ext_pend;
                        is_break   <= brk_pend;
                    end
                end
            end
        end
    end
endmodule
